fill_trigger_scheduler: RTL
===========================

# fill_trigger_scheduler

Sequences fill acquisition for the waveform digitizer and feeds fill descriptors to the AMC13 readout path. It arms the digitizer channels and accepts one trigger per armed window. After every enabled channel reports completion, it queues a 28-bit fill word `{fill_type, trig_num}` into an internal FIFO. The readout manager pops this FIFO through `fifo_read_en`/`fifo_data`/`fifo_empty`, and the block holds that manager's `pause` input high while channels are digitizing.

## Interface
Parameters:
- `NUM_CHAN`, 5: number of digitizer channels.
- `FIFO_DEPTH`, 8: fill-word FIFO depth; must be a power of 2, minimum 2.
- `TRIG_NUM_W`, 24: trigger-number width.
- `FILL_TYPE_W`, 4: fill-type width.

Ports:
- `clk_in` in 1: single clock. All logic runs on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `trigger` in 1: one-cycle pulse requesting a new fill.
- `fill_type` in 4: sampled in the cycle `trigger` is high.
- `chan_enable` in `NUM_CHAN`: disabled channels count as done. Sampled when a trigger is accepted.
- `chan_done` in `NUM_CHAN`: per-channel completion pulse or level.
- `chan_armed` out `NUM_CHAN`: arm strobe to the channels, registered.
- `fifo_read_en` in 1: pop request from the readout manager.
- `fifo_data` out 28: fill word `{fill_type[3:0], trig_num[23:0]}`.
- `fifo_empty` out 1: FIFO holds no entries.
- `pause` out 1: high during acquisition.
- `trig_num` out 24: number the next accepted trigger will receive.
- `trig_lost` out 1: sticky flag; a trigger arrived while the block was not ARMED.

## Operation
- Reset values:
  - state = IDLE.
  - `chan_armed` = 0, `pause` = 0, `trig_lost` = 0.
  - `trig_num` = 0, `fifo_data` = 0, `fifo_empty` = 1.
  - FIFO pointers and count = 0; `done_mask` = 0; latched `fill_type` = 0.
- State machine (registered outputs):
  - **IDLE**: one cycle after reset release, then go to ARMED.
  - **ARMED**: `chan_armed` = all ones.
    - On `trigger`: latch `fill_type`, `chan_enable` and `trig_num`; load `done_mask` = ~`chan_enable`; go to ACQUIRE.
  - **ACQUIRE**: `chan_armed` = 0, `pause` = 1.
    - Each cycle: `done_mask` |= `chan_done`.
    - When (`done_mask` | `chan_done`) is all ones, go to STORE. This is evaluated in the same cycle, so a final done pulse is not lost.
  - **STORE**: `pause` = 0.
    - If the FIFO is not full: write the fill word, increment `trig_num` (modulo 2^24, so FFFFFF wraps to 000000), go to ARMED.
    - If the FIFO is full: stay in STORE until a pop frees an entry.
- `trigger` in any state other than ARMED: ignored and `trig_lost` is set. `trig_num` does not change. `trig_lost` clears only on reset.
- If all channels are disabled, ACQUIRE lasts exactly one cycle.
- FIFO read:
  - `fifo_read_en` with `fifo_empty` = 0: `fifo_data` is loaded with the head entry on the next edge and held until the next pop.
  - `fifo_read_en` with `fifo_empty` = 1: ignored, no pointer movement, `fifo_data` holds.
- Simultaneous read and write: the count is unchanged and both pointers advance.
  - Full is evaluated from the registered count, so a pop in cycle N lets STORE write in cycle N+1.
  - Read of an empty FIFO in the same cycle as a write does not return the new word; the word becomes visible on a later pop.
- Reset mid-operation: everything returns to reset values immediately. Queued fills are discarded.

## Timing
- Trigger to `pause` high: 1 cycle (registered).
- Last `chan_done` to STORE: 1 cycle.
- STORE (not full) to fill word in the FIFO and `fifo_empty` low: 1 cycle.
- STORE to `chan_armed` high again: 1 cycle.
- Read latency: `fifo_read_en` at edge N gives a valid `fifo_data` after edge N+1. This matches a consumer that requests in one state and samples in the next.
- Minimum trigger spacing: 3 cycles (ARMED → ACQUIRE → STORE → ARMED) when no channel is enabled.

## Structure
- Package `wfd_fill_pkg`:
  - `TRIG_NUM_W`, `FILL_TYPE_W` and `FILL_WORD_W` = 28.
  - Fill-word pack/unpack functions.
  - State encoding enum: IDLE, ARMED, ACQUIRE, STORE.
- Sub-module `fill_word_fifo`: synchronous FIFO with registered read port and `full`/`empty`/`count`, parameterized by width and depth. The top level holds the FSM, `done_mask`, trigger counter and lost flag.

## Test plan
- **Single fill**: reset, `trigger` with `fill_type`=3, all five channels pulse `chan_done` on staggered cycles.
  - `pause` is high from trigger+1 until the last done+1.
  - `fifo_data` = 0x3000000 after one pop; `trig_num` = 1.
- **Lost trigger**: second `trigger` during ACQUIRE.
  - `trig_lost` = 1 and stays 1.
  - Only one FIFO entry; `trig_num` increments only once.
- **FIFO full**: 8 fills with no reads, then a 9th fill completes.
  - FSM stays in STORE and `chan_armed` stays 0.
  - One pop → the 9th word is written the next cycle with number 8.
- **Wrap and disabled channels**: preload 0xFFFFFF via repeated fills (or force), `chan_enable`=5'b00001.
  - Only channel 0 needs to be done; the word carries 0xFFFFFF, then `trig_num` = 0.
- **Reset mid-ACQUIRE with 3 queued entries**: all outputs return to reset values (`fifo_empty`=1, `trig_num`=0); after 2 cycles `chan_armed` = 5'b11111.
- **Empty read**: `fifo_read_en` while empty gives no change to `fifo_data`; a simultaneous read and write on an empty FIFO leaves count=1.

Source files
------------

// File: rtl/wfd_fill_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : wfd_fill_pkg                                               |
// | Brief   : Shared widths, FSM state encoding and fill-word helpers    |
// |           for the waveform-digitizer fill trigger scheduler.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package wfd_fill_pkg;

  localparam int TRIG_NUM_W  = 24;
  localparam int FILL_TYPE_W = 4;
  localparam int FILL_WORD_W = FILL_TYPE_W + TRIG_NUM_W;

  // Scheduler states, two-bit encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    ACQUIRE = 2'd2,
    STORE   = 2'd3
  } fill_state_t;

  // Fill word layout: fill type in the top nibble, trigger number below
  function automatic logic [FILL_WORD_W-1:0] pack_fill_word(
    input logic [FILL_TYPE_W-1:0] ftype,
    input logic [TRIG_NUM_W-1:0]  tnum
  );
    return {ftype, tnum};
  endfunction

  function automatic logic [FILL_TYPE_W-1:0] unpack_fill_type(
    input logic [FILL_WORD_W-1:0] word
  );
    return word[FILL_WORD_W-1 -: FILL_TYPE_W];
  endfunction

  function automatic logic [TRIG_NUM_W-1:0] unpack_trig_num(
    input logic [FILL_WORD_W-1:0] word
  );
    return word[TRIG_NUM_W-1:0];
  endfunction

endpackage : wfd_fill_pkg
`default_nettype wire

// File: rtl/fill_word_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fill_word_fifo                                             |
// | Brief   : Synchronous FIFO with a registered read port and           |
// |           full/empty/count status derived from a registered count.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fill_word_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8   // power of two, at least 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] c_ptr_one   = 1;
  localparam logic [CNT_W-1:0] c_cnt_one   = 1;
  localparam logic [CNT_W-1:0] c_cnt_depth = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rd_data;

  logic w_do_wr;
  logic w_do_rd;

  // Status comes from the registered count only, so a pop frees space
  // for a write on the following edge, never the same one.
  assign full    = (r_count == c_cnt_depth);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_rd_data;

  // Requests against a full/empty FIFO are dropped here.
  assign w_do_wr = wr_en & ~full;
  assign w_do_rd = rd_en & ~empty;

  // Storage array: no reset needed, contents are qualified by the count
  always_ff @(posedge clk_in) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy count and the registered read word
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_do_rd) begin
        r_rd_ptr  <= r_rd_ptr + c_ptr_one;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : fill_word_fifo
`default_nettype wire

// File: rtl/fill_trigger_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fill_trigger_scheduler                                     |
// | Brief   : Arms the digitizer channels, accepts one trigger per armed |
// |           window, waits for every enabled channel to finish and      |
// |           queues a {fill_type, trig_num} word for the readout path.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fill_trigger_scheduler #(
  parameter int NUM_CHAN    = 5,
  parameter int FIFO_DEPTH  = 8,
  parameter int TRIG_NUM_W  = 24,
  parameter int FILL_TYPE_W = 4
) (
  input  logic                              clk_in,
  input  logic                              rst_n,
  input  logic                              trigger,
  input  logic [FILL_TYPE_W-1:0]            fill_type,
  input  logic [NUM_CHAN-1:0]               chan_enable,
  input  logic [NUM_CHAN-1:0]               chan_done,
  output logic [NUM_CHAN-1:0]               chan_armed,
  input  logic                              fifo_read_en,
  output logic [FILL_TYPE_W+TRIG_NUM_W-1:0] fifo_data,
  output logic                              fifo_empty,
  output logic                              pause,
  output logic [TRIG_NUM_W-1:0]             trig_num,
  output logic                              trig_lost
);

  import wfd_fill_pkg::*;

  localparam int WORD_W = FILL_TYPE_W + TRIG_NUM_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [NUM_CHAN-1:0]   c_all_chan   = '1;
  localparam logic [TRIG_NUM_W-1:0] c_trig_one   = 1;
  localparam logic [CNT_W-1:0]      c_fifo_depth = CNT_W'(FIFO_DEPTH);

  fill_state_t             r_state;
  logic [NUM_CHAN-1:0]     r_done_mask;
  logic [NUM_CHAN-1:0]     r_chan_enable;
  logic [FILL_TYPE_W-1:0]  r_fill_type;
  logic [TRIG_NUM_W-1:0]   r_trig_latched;
  logic [TRIG_NUM_W-1:0]   r_trig_num;
  logic [NUM_CHAN-1:0]     r_chan_armed;
  logic                    r_pause;
  logic                    r_trig_lost;

  logic [NUM_CHAN-1:0]     w_done_next;
  logic                    w_all_done;
  logic                    w_fifo_wr;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [CNT_W-1:0]        w_fifo_count;
  logic [WORD_W-1:0]       w_fill_word;
  logic [WORD_W-1:0]       w_fifo_rd_data;

  // Disabled channels were preset in the mask at trigger time; only
  // enabled channels may contribute new done bits.
  assign w_done_next = r_done_mask | (chan_done & r_chan_enable);
  // Includes this cycle's done pulses so a final pulse is not missed.
  assign w_all_done  = &w_done_next;

  assign w_fill_word = {r_fill_type, r_trig_latched};
  assign w_fifo_wr   = (r_state == STORE) && !w_fifo_full;

  assign chan_armed  = r_chan_armed;
  assign pause       = r_pause;
  assign trig_num    = r_trig_num;
  assign trig_lost   = r_trig_lost;
  assign fifo_data   = w_fifo_rd_data;
  assign fifo_empty  = w_fifo_empty;

  // Acquisition sequencer with registered arm/pause outputs, trigger
  // counter and sticky lost-trigger flag
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_done_mask    <= '0;
      r_chan_enable  <= '0;
      r_fill_type    <= '0;
      r_trig_latched <= '0;
      r_trig_num     <= '0;
      r_chan_armed   <= '0;
      r_pause        <= 1'b0;
      r_trig_lost    <= 1'b0;
    end else begin
      if (trigger && (r_state != ARMED)) begin
        r_trig_lost <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_chan_armed <= c_all_chan;
          r_state      <= ARMED;
        end
        ARMED: begin
          if (trigger) begin
            r_fill_type    <= fill_type;
            r_chan_enable  <= chan_enable;
            r_trig_latched <= r_trig_num;
            r_done_mask    <= ~chan_enable;
            r_chan_armed   <= '0;
            r_pause        <= 1'b1;
            r_state        <= ACQUIRE;
          end
        end
        ACQUIRE: begin
          r_done_mask <= w_done_next;
          if (w_all_done) begin
            r_pause <= 1'b0;
            r_state <= STORE;
          end
        end
        STORE: begin
          // Wait here with the channels disarmed until a pop frees space
          if (!w_fifo_full) begin
            r_trig_num   <= r_trig_num + c_trig_one;
            r_chan_armed <= c_all_chan;
            r_state      <= ARMED;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  fill_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fill_word_fifo (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .wr_en   (w_fifo_wr),
    .wr_data (w_fill_word),
    .rd_en   (fifo_read_en),
    .rd_data (w_fifo_rd_data),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  // The full flag and the occupancy count must always agree
  a_full_matches_count : assert property (
    @(posedge clk_in) disable iff (!rst_n)
      w_fifo_full == (w_fifo_count == c_fifo_depth)
  );

endmodule : fill_trigger_scheduler
`default_nettype wire
